fetch_pc_ctrl: RTL

Fetch-address sequencer between the instruction fetch unit, the ALU broadcast bus and the ROB. It owns the architectural fetch PC. Each instruction IF delivers is decoded just far enough to choose the next PC. Sources, in priority order:
- ROB misprediction redirect
- resolved JALR target
- predicted jump/branch target
- PC+4

Branch direction comes from an optional 2-bit BHT that is trained by ROB commits.

---
 rtl/fetch_pc_ctrl_pkg.sv | 23 ++
 rtl/bht_table.sv | 59 +++++
 rtl/fetch_pc_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_pkg
// Shared constants for the fetch-address sequencer: RV32 opcode values used
// for next-PC selection, address/instruction widths, the ALU opcode width and
// the ALU code that marks a JALR target broadcast, plus TRUE/FALSE shorthands.
// -----------------------------------------------------------------------------
package fetch_pc_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int INSTRLEN = 32;
    localparam int OPLEN    = 6;

    localparam logic [6:0] OPC_JAL    = 7'd111;
    localparam logic [6:0] OPC_JALR   = 7'd103;
    localparam logic [6:0] OPC_BRANCH = 7'd99;

    // ALU result opcode carried on the broadcast bus when it resolves a JALR.
    localparam logic [OPLEN-1:0] ALU_OP_JALR = 6'd13;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/bht_table.sv
// -----------------------------------------------------------------------------
// bht_table
// Branch history table: 2^IDX_W two-bit saturating counters, all reset to
// weakly-not-taken. One combinational read port (lookup) and one update port
// (ROB commit). A same-index read and update in one cycle returns the value
// held before the update.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; table holds when low
//   rd_idx / rd_cnt   lookup index and counter value
//   upd_en            train the counter at upd_idx
//   upd_idx           index to train
//   upd_taken         1 = count up, 0 = count down
// -----------------------------------------------------------------------------
module bht_table #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];
    logic [1:0] upd_cur;

    assign rd_cnt  = cnt_q[rd_idx];
    assign upd_cur = cnt_q[upd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            if (upd_taken && (upd_cur != 2'b11)) begin
                cnt_d[upd_idx] = upd_cur + 2'b01;
            end else if (!upd_taken && (upd_cur != 2'b00)) begin
                cnt_d[upd_idx] = upd_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (rdy) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
// Owns the fetch PC. Each delivered instruction is pre-decoded just enough to
// pick the next fetch address: ROB redirect > resolved JALR > predicted
// jal/branch target > PC+4. JALR stalls fetch until the ALU broadcasts its
// target.
//
// Build option: define BHT_EN to predict branches with a 2-bit BHT trained by
// ROB commits; without it branches are predicted statically taken and the
// rob_commit_* inputs are ignored.
//
// Ports:
//   clk, rst, rdy                      clock, sync reset, global ready
//   if_success/if_instr/if_instr_pc    instruction delivered by IF
//   alu_broadcast/_op/alu_jumping_pc   ALU result bus (JALR target)
//   jump_wrong/jump_to_pc_from_rob     ROB misprediction redirect
//   rob_commit_branch/_pc/_taken       BHT training
//   fetch_pc_valid/fetch_pc            one-cycle fetch request
//   pred_is_jump/pred_taken/pred_target prediction sent to the ROB
//
// state       | meaning
// S_START     | after reset, issue RESET_PC
// S_RUN       | predict next PC for each delivered instruction
// S_WAIT_JALR | fetch stalled until the ALU resolves a JALR target
// -----------------------------------------------------------------------------
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BHT_IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             if_success,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_instr_pc,
    input  logic             alu_broadcast,
    input  logic [OPLEN-1:0] alu_broadcast_op,
    input  logic [31:0]      alu_jumping_pc,
    input  logic             jump_wrong,
    input  logic [31:0]      jump_to_pc_from_rob,
    input  logic             rob_commit_branch,
    input  logic [31:0]      rob_commit_pc,
    input  logic             rob_commit_taken,
    output logic             fetch_pc_valid,
    output logic [31:0]      fetch_pc,
    output logic             pred_is_jump,
    output logic             pred_taken,
    output logic [31:0]      pred_target
);

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_WAIT_JALR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fetch_pc_valid_q, fetch_pc_valid_d;
    logic        pred_is_jump_q, pred_is_jump_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;

    logic [31:0]          imm_j, imm_b;
    logic                 branch_taken;
    logic [BHT_IDX_W-1:0] lookup_idx;

    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign lookup_idx = if_instr_pc[BHT_IDX_W+1:2];

`ifdef BHT_EN
    logic [1:0] bht_cnt;
    logic       unused_bht;

    bht_table #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (lookup_idx),
        .rd_cnt    (bht_cnt),
        .upd_en    (rob_commit_branch),
        .upd_idx   (rob_commit_pc[BHT_IDX_W+1:2]),
        .upd_taken (rob_commit_taken)
    );

    assign branch_taken = bht_cnt[1];
    assign unused_bht   = ^{rob_commit_pc[31:BHT_IDX_W+2], rob_commit_pc[1:0], bht_cnt[0]};
`else
    logic unused_bht;

    assign branch_taken = TRUE;
    assign unused_bht   = ^{rob_commit_branch, rob_commit_pc, rob_commit_taken, lookup_idx};
`endif

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        fetch_pc_valid_d = fetch_pc_valid_q;
        pred_is_jump_d   = pred_is_jump_q;
        pred_taken_d     = pred_taken_q;
        pred_target_d    = pred_target_q;

        // With rdy low everything holds, including a pulse already on the outputs.
        if (rdy) begin
            fetch_pc_valid_d = FALSE;
            if (jump_wrong) begin
                fetch_pc_d       = jump_to_pc_from_rob;
                fetch_pc_valid_d = TRUE;
                state_d          = S_RUN;
            end else begin
                case (state_q)
                    S_START: begin
                        fetch_pc_d       = RESET_PC;
                        fetch_pc_valid_d = TRUE;
                        state_d          = S_RUN;
                    end
                    S_RUN: begin
                        if (if_success) begin
                            case (if_instr[6:0])
                                OPC_JAL: begin
                                    fetch_pc_d       = if_instr_pc + imm_j;
                                    fetch_pc_valid_d = TRUE;
                                    pred_is_jump_d   = TRUE;
                                    pred_taken_d     = TRUE;
                                    pred_target_d    = if_instr_pc + imm_j;
                                end
                                OPC_BRANCH: begin
                                    fetch_pc_d       = branch_taken ? (if_instr_pc + imm_b)
                                                                    : (if_instr_pc + 32'd4);
                                    fetch_pc_valid_d = TRUE;
                                    pred_is_jump_d   = TRUE;
                                    pred_taken_d     = branch_taken;
                                    pred_target_d    = branch_taken ? (if_instr_pc + imm_b)
                                                                    : (if_instr_pc + 32'd4);
                                end
                                OPC_JALR: begin
                                    pred_is_jump_d = TRUE;
                                    pred_taken_d   = TRUE;
                                    state_d        = S_WAIT_JALR;
                                end
                                default: begin
                                    fetch_pc_d       = if_instr_pc + 32'd4;
                                    fetch_pc_valid_d = TRUE;
                                    pred_is_jump_d   = FALSE;
                                    pred_taken_d     = FALSE;
                                    pred_target_d    = if_instr_pc + 32'd4;
                                end
                            endcase
                        end
                    end
                    S_WAIT_JALR: begin
                        if (alu_broadcast && (alu_broadcast_op == ALU_OP_JALR)) begin
                            fetch_pc_d       = alu_jumping_pc;
                            fetch_pc_valid_d = TRUE;
                            pred_target_d    = alu_jumping_pc;
                            state_d          = S_RUN;
                        end
                    end
                    default: state_d = S_START;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_START;
            fetch_pc_q       <= RESET_PC;
            fetch_pc_valid_q <= FALSE;
            pred_is_jump_q   <= FALSE;
            pred_taken_q     <= FALSE;
            pred_target_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            fetch_pc_valid_q <= fetch_pc_valid_d;
            pred_is_jump_q   <= pred_is_jump_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
        end
    end

    assign fetch_pc_valid = fetch_pc_valid_q;
    assign fetch_pc       = fetch_pc_q;
    assign pred_is_jump   = pred_is_jump_q;
    assign pred_taken     = pred_taken_q;
    assign pred_target    = pred_target_q;

endmodule
